panel_scan_sequencer: RTL



---
 rtl/scan_pkg.sv | 31 +++
 rtl/bcm_oe_timer.sv | 54 +++++
 rtl/panel_scan_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared state encoding, default sizing and width helpers for panel_scan_sequencer.
// The optional SCAN_DEAD_TIME_EN build adds OE blanking after each latch.
package scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CLK,
    S_WAIT_OE,
    S_LATCH
  } scan_state_t;

  localparam int DEF_PIXEL_WIDTH      = 64;
  localparam int DEF_PIXEL_HALFHEIGHT = 16;
  localparam int DEF_BITPLANES        = 8;
  localparam int DEF_FETCH_CYCLES     = 3;
  localparam int DEF_BASE_OE_CYCLES   = 2;
  localparam int DEF_DEAD_TIME        = 2;

  // Index width for a 0..n-1 counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // OE counter must hold the longest window, BASE << (planes-1).
  function automatic int oe_cnt_width(input int base, input int planes);
    return $clog2((base << (planes - 1)) + 1);
  endfunction

endpackage

// File: rtl/bcm_oe_timer.sv
// BCM output-enable window timer: loads a window length, counts it down, and
// (with SCAN_DEAD_TIME_EN) holds OE off for DEAD_TIME cycles before counting.
module bcm_oe_timer #(
  parameter int CNT_W     = 3,
  parameter int DEAD_TIME = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             blank,
  output logic             oe_n,
  output logic             busy
);

  localparam int DEAD_W = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEAD_W-1:0] dead_q, dead_d;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    cnt_d  = cnt_q;
    dead_d = dead_q;
    if (load) begin
      cnt_d = load_val;
`ifdef SCAN_DEAD_TIME_EN
      dead_d = DEAD_W'(DEAD_TIME);
`else
      dead_d = '0;
`endif
    end else if (dead_q != '0) begin
      // Window count is frozen while blanking so the full length is shown.
      dead_d = dead_q - DEAD_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking here so all flops update from pre-edge values together.
    if (!rst_n) begin
      cnt_q  <= '0;
      dead_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dead_q <= dead_d;
    end
  end

  assign busy = (cnt_q != '0) || (dead_q != '0);
  assign oe_n = blank || (cnt_q == '0) || (dead_q != '0);

endmodule

// File: rtl/panel_scan_sequencer.sv
// HUB75 scan sequencer: fetch addressing, shift clock, row latch and BCM OE timing.
// Define SCAN_DEAD_TIME_EN to blank OE for DEAD_TIME cycles after every latch.
module panel_scan_sequencer
  import scan_pkg::*;
#(
  parameter int PIXEL_WIDTH      = DEF_PIXEL_WIDTH,
  parameter int PIXEL_HALFHEIGHT = DEF_PIXEL_HALFHEIGHT,
  parameter int BITPLANES        = DEF_BITPLANES,
  parameter int FETCH_CYCLES     = DEF_FETCH_CYCLES,
  parameter int BASE_OE_CYCLES   = DEF_BASE_OE_CYCLES,
  parameter int DEAD_TIME        = DEF_DEAD_TIME
) (
  input  logic                                   clk_in,
  input  logic                                   reset_n,
  input  logic                                   enable,
  output logic [idx_width(PIXEL_WIDTH)-1:0]      column_address,
  output logic [idx_width(PIXEL_HALFHEIGHT)-1:0] row_address,
  output logic                                   pixel_load_start,
  output logic [idx_width(BITPLANES)-1:0]        bitplane,
  output logic                                   pixel_clock,
  output logic                                   row_latch,
  output logic                                   output_enable_n,
  output logic [idx_width(PIXEL_HALFHEIGHT)-1:0] row_select,
  output logic                                   frame_done
);

  localparam int COL_W  = idx_width(PIXEL_WIDTH);
  localparam int ROW_W  = idx_width(PIXEL_HALFHEIGHT);
  localparam int PLN_W  = idx_width(BITPLANES);
  localparam int WAIT_W = idx_width(FETCH_CYCLES);
  localparam int OE_W   = oe_cnt_width(BASE_OE_CYCLES, BITPLANES);

  scan_state_t       state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  rsel_q, rsel_d;
  logic [PLN_W-1:0]  plane_q, plane_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              last_col, last_row, last_plane;
  logic              oe_load, oe_busy, oe_n;
  logic [OE_W-1:0]   oe_load_val;

  assign last_col    = (col_q == COL_W'(PIXEL_WIDTH - 1));
  assign last_row    = (row_q == ROW_W'(PIXEL_HALFHEIGHT - 1));
  assign last_plane  = (plane_q == PLN_W'(BITPLANES - 1));
  assign oe_load_val = OE_W'(BASE_OE_CYCLES << plane_q);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    rsel_d     = rsel_q;
    plane_d    = plane_q;
    wait_d     = wait_q;
    oe_load    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          col_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        wait_d  = WAIT_W'(FETCH_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_CLK;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_CLK: begin
        if (!last_col) begin
          col_d   = col_q + COL_W'(1);
          state_d = S_START;
        end else if (oe_busy) begin
          state_d = S_WAIT_OE;
        end else begin
          state_d = S_LATCH;
        end
      end
      S_WAIT_OE: begin
        if (!oe_busy) state_d = S_LATCH;
      end
      S_LATCH: begin
        // Display the row just shifted while the fetch side moves on.
        oe_load = 1'b1;
        rsel_d  = row_q;
        col_d   = '0;
        if (last_plane) begin
          plane_d = '0;
          if (last_row) begin
            row_d      = '0;
            frame_done = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          plane_d = plane_q + PLN_W'(1);
        end
        state_d = enable ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      rsel_q  <= '0;
      plane_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rsel_q  <= rsel_d;
      plane_q <= plane_d;
      wait_q  <= wait_d;
    end
  end

  bcm_oe_timer #(
    .CNT_W     (OE_W),
    .DEAD_TIME (DEAD_TIME)
  ) u_oe_timer (
    .clk      (clk_in),
    .rst_n    (reset_n),
    .load     (oe_load),
    .load_val (oe_load_val),
    .blank    (state_q == S_LATCH),
    .oe_n     (oe_n),
    .busy     (oe_busy)
  );

  assign column_address   = col_q;
  assign row_address      = row_q;
  assign bitplane         = plane_q;
  assign row_select       = rsel_q;
  assign pixel_load_start = (state_q == S_START);
  assign pixel_clock      = (state_q == S_CLK);
  assign row_latch        = (state_q == S_LATCH);
  assign output_enable_n  = oe_n;

endmodule
